// File: rtl/bp_be_accel_issue_sched.sv
// ----------------------------------------------------------------------------
// bp_be_accel_issue_sched
//
// This is the issue scheduler for the weight-stationary systolic core in the
// accelerator pipe. It pairs the head op of the op queue with the head beat of
// the data queue and issues the pair to the core in the same cycle. It also:
//   - enforces the weight-load order (WTLD0, then WTLD1, then activations),
//   - limits activation issue to the free writeback-buffer credits,
//   - generates the uncached-store address for each result beat.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   op_i, op_v_i          head op (0=ACLD0 1=ACLD1 2=WTLD0 3=WTLD1), op queue valid
//   op_yumi_o             pop the op queue
//   data_v_i, data_yumi_o data queue valid, pop the data queue
//   core_op_o, core_v_o   op and issue strobe to the core (the core always accepts)
//   wb_yumi_i             the store pump accepted one result beat
//   base_addr_i, base_w_i destination base address and its CSR write strobe
//   wb_addr_o             store address for the current result beat
//   wt_valid_o            both weight halves are loaded
//   err_o                 sticky protocol error; cleared only by reset
//   busy_o                results are outstanding, or a valid pair is stalled
// ----------------------------------------------------------------------------
module bp_be_accel_issue_sched #(
    parameter int credits_p     = 2,
    parameter int paddr_width_p = 40,
    parameter int stride_p      = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [1:0]               op_i,
    input  logic                     op_v_i,
    output logic                     op_yumi_o,
    input  logic                     data_v_i,
    output logic                     data_yumi_o,
    output logic [1:0]               core_op_o,
    output logic                     core_v_o,
    input  logic                     wb_yumi_i,
    input  logic [paddr_width_p-1:0] base_addr_i,
    input  logic                     base_w_i,
    output logic [paddr_width_p-1:0] wb_addr_o,
    output logic                     wt_valid_o,
    output logic                     err_o,
    output logic                     busy_o
);

    localparam int cred_w_lp = $clog2(credits_p + 1);
    localparam logic [cred_w_lp-1:0]     credits_full_lp = cred_w_lp'(credits_p);
    localparam logic [paddr_width_p-1:0] stride_lp       = paddr_width_p'(stride_p);

    localparam logic [1:0] op_wtld0_lp = 2'd2;
    localparam logic [1:0] op_wtld1_lp = 2'd3;

    typedef enum logic [1:0] {
        E_EMPTY = 2'd0,
        E_HALF  = 2'd1,
        E_ARMED = 2'd2
    } wt_state_e;

    wt_state_e                  state_r;
    logic [cred_w_lp-1:0]       credits_r;
    logic [paddr_width_p-1:0]   base_r;
    logic [paddr_width_p-1:0]   offset_r;
    logic                       err_r;

    logic pv;
    logic is_wt;
    logic credits_full;
    logic issue_now;
    logic acld_err;
    logic acld_issue;
    logic wt1_err;
    logic wb_overflow;

    // Issue decision. It is combinational so that a pair can issue in the same
    // cycle it becomes valid. Reset forces the strobes low so that nothing is
    // popped or issued while the registers are being cleared.
    always_comb begin
        // NOTE: each signal gets a default first, so no path through this
        // block leaves a value unassigned and no latch is inferred.
        pv           = op_v_i & data_v_i & ~reset_i;
        is_wt        = op_i[1];
        credits_full = (credits_r == credits_full_lp);
        issue_now    = 1'b0;
        acld_err     = 1'b0;

        if (pv) begin
            if (is_wt) begin
                // Weights change only when the buffer is drained.
                issue_now = credits_full;
            end else if (state_r == E_ARMED) begin
                issue_now = (credits_r != '0);
            end else begin
                // An activation before the weights are armed is dropped.
                acld_err = 1'b1;
            end
        end

        acld_issue  = issue_now & ~is_wt;
        wt1_err     = issue_now & (op_i == op_wtld1_lp) & (state_r != E_HALF);
        wb_overflow = wb_yumi_i & credits_full;
    end

    assign core_v_o    = issue_now;
    assign core_op_o   = op_i;
    assign op_yumi_o   = issue_now | acld_err;
    assign data_yumi_o = issue_now | acld_err;
    assign wb_addr_o   = base_r + offset_r;
    assign wt_valid_o  = (state_r == E_ARMED);
    assign err_o       = err_r;
    assign busy_o      = ~reset_i & (~credits_full | (pv & ~issue_now));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register here samples the same pre-edge values.
            state_r   <= E_EMPTY;
            credits_r <= credits_full_lp;
            base_r    <= '0;
            offset_r  <= '0;
            err_r     <= 1'b0;
        end else begin
            // Weight-load ordering.
            if (issue_now && is_wt) begin
                if (op_i == op_wtld0_lp) begin
                    state_r <= E_HALF;
                end else if (state_r == E_HALF) begin
                    state_r <= E_ARMED;
                end else begin
                    state_r <= E_EMPTY;
                end
            end

            // Credit accounting. When an issue and a retire happen in the same
            // cycle they cancel, and a retire with no results in flight is ignored.
            unique case ({acld_issue, wb_yumi_i})
                2'b10:   credits_r <= credits_r - cred_w_lp'(1);
                2'b01:   if (!credits_full) credits_r <= credits_r + cred_w_lp'(1);
                default: credits_r <= credits_r;
            endcase

            // Store address. A new base takes priority over a beat advance.
            if (base_w_i) begin
                base_r   <= base_addr_i;
                offset_r <= '0;
            end else if (wb_yumi_i) begin
                offset_r <= offset_r + stride_lp;
            end

            if (acld_err || wt1_err || wb_overflow) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_be_accel_issue_sched.sv
// ----------------------------------------------------------------------------
// tb_bp_be_accel_issue_sched
//
// Self-checking bench for bp_be_accel_issue_sched with the default parameters
// (credits 2, 40-bit addresses, 16-byte stride). It has three parts:
//   1. A table of single-cycle vectors that walks through weight loading,
//      credit stalls, the weight-reload stall and the protocol errors.
//   2. A hand-written sequence for address stepping and same-cycle collisions.
//   3. Random traffic compared against a behavioural model.
// ----------------------------------------------------------------------------
module tb_bp_be_accel_issue_sched;

    localparam int CREDITS = 2;
    localparam int AW      = 40;
    localparam int STRIDE  = 16;
    localparam longint unsigned AMASK = (64'd1 << AW) - 64'd1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [1:0]    op_i;
    logic          op_v_i;
    logic          op_yumi_o;
    logic          data_v_i;
    logic          data_yumi_o;
    logic [1:0]    core_op_o;
    logic          core_v_o;
    logic          wb_yumi_i;
    logic [AW-1:0] base_addr_i;
    logic          base_w_i;
    logic [AW-1:0] wb_addr_o;
    logic          wt_valid_o;
    logic          err_o;
    logic          busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    bp_be_accel_issue_sched #(
        .credits_p    (CREDITS),
        .paddr_width_p(AW),
        .stride_p     (STRIDE)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .op_i       (op_i),
        .op_v_i     (op_v_i),
        .op_yumi_o  (op_yumi_o),
        .data_v_i   (data_v_i),
        .data_yumi_o(data_yumi_o),
        .core_op_o  (core_op_o),
        .core_v_o   (core_v_o),
        .wb_yumi_i  (wb_yumi_i),
        .base_addr_i(base_addr_i),
        .base_w_i   (base_w_i),
        .wb_addr_o  (wb_addr_o),
        .wt_valid_o (wt_valid_o),
        .err_o      (err_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge. Outputs are sampled 1 ns later, well
    // before the next rising edge.
    task automatic drive(input logic rst, input logic [1:0] op, input logic ov,
                         input logic dv, input logic wb, input logic bw,
                         input logic [AW-1:0] base);
        @(negedge clk);
        reset_i     = rst;
        op_i        = op;
        op_v_i      = ov;
        data_v_i    = dv;
        wb_yumi_i   = wb;
        base_w_i    = bw;
        base_addr_i = base;
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] op;
        logic       op_v;
        logic       data_v;
        logic       wb;
        logic       e_core_v;
        logic       e_yumi;
        logic       e_wt;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vecs[18];

    // ---------------- behavioural reference model ----------------
    // Loaded weight halves are kept as a list: the weights are armed when
    // the list is exactly {WTLD0, WTLD1}.
    int              m_halves[$];
    int              m_inflight;
    bit              m_err;
    longint unsigned m_base;
    longint unsigned m_beats;

    function automatic bit m_armed();
        return (m_halves.size() == 2);
    endfunction

    task automatic m_reset();
        m_halves.delete();
        m_inflight = 0;
        m_err      = 1'b0;
        m_base     = 0;
        m_beats    = 0;
    endtask

    initial begin
        bit              pv;
        bit              is_wt;
        bit              can_issue;
        bit              bad_acld;
        bit              wb;
        int              nxt;
        logic [1:0]      rop;
        logic [AW-1:0]   rbase;
        longint unsigned exp_addr;

        // Columns: rst, op, op_v, data_v, wb_yumi | core_v, yumi, wt_valid, busy, err
        vecs[0]  = '{0, 2'd0, 0, 0, 0,  0, 0, 0, 0, 0}; // idle after reset
        vecs[1]  = '{0, 2'd2, 1, 1, 0,  1, 1, 0, 0, 0}; // WTLD0 issues
        vecs[2]  = '{0, 2'd3, 1, 1, 0,  1, 1, 0, 0, 0}; // WTLD1 issues
        vecs[3]  = '{0, 2'd0, 0, 0, 0,  0, 0, 1, 0, 0}; // armed
        vecs[4]  = '{0, 2'd0, 1, 1, 0,  1, 1, 1, 0, 0}; // ACLD0 #1
        vecs[5]  = '{0, 2'd0, 1, 1, 0,  1, 1, 1, 1, 0}; // ACLD0 #2
        vecs[6]  = '{0, 2'd0, 1, 1, 0,  0, 0, 1, 1, 0}; // ACLD0 #3 stalls
        vecs[7]  = '{0, 2'd0, 1, 1, 1,  0, 0, 1, 1, 0}; // still stalled, one retire
        vecs[8]  = '{0, 2'd0, 1, 1, 0,  1, 1, 1, 1, 0}; // ACLD0 #3 issues
        vecs[9]  = '{0, 2'd0, 0, 0, 1,  0, 0, 1, 1, 0}; // retire, 1 still out
        vecs[10] = '{0, 2'd2, 1, 1, 1,  0, 0, 1, 1, 0}; // WTLD0 waits for drain
        vecs[11] = '{0, 2'd2, 1, 1, 0,  1, 1, 1, 0, 0}; // WTLD0 issues when drained
        vecs[12] = '{0, 2'd0, 0, 0, 0,  0, 0, 0, 0, 0}; // reload -> half, not armed
        vecs[13] = '{1, 2'd1, 1, 1, 0,  0, 0, 0, 0, 0}; // reset masks the pair
        vecs[14] = '{0, 2'd1, 1, 1, 0,  0, 1, 0, 1, 0}; // ACLD1 unarmed: popped, no issue
        vecs[15] = '{0, 2'd0, 0, 0, 0,  0, 0, 0, 0, 1}; // sticky error
        vecs[16] = '{0, 2'd3, 1, 1, 0,  1, 1, 0, 0, 1}; // WTLD1 from empty still issues
        vecs[17] = '{0, 2'd0, 0, 0, 0,  0, 0, 0, 0, 1}; // stays empty

        drive(1, 2'd0, 0, 0, 0, 0, '0);
        drive(1, 2'd0, 0, 0, 0, 0, '0);

        // ---------------- part 1: vector table ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].op_v, vecs[i].data_v, vecs[i].wb, 0, '0);
            check($sformatf("vec%0d core_v", i), 64'(core_v_o),    64'(vecs[i].e_core_v));
            check($sformatf("vec%0d op_yumi", i), 64'(op_yumi_o),  64'(vecs[i].e_yumi));
            check($sformatf("vec%0d data_yumi", i), 64'(data_yumi_o), 64'(vecs[i].e_yumi));
            check($sformatf("vec%0d wt_valid", i), 64'(wt_valid_o), 64'(vecs[i].e_wt));
            check($sformatf("vec%0d busy", i), 64'(busy_o),        64'(vecs[i].e_busy));
            check($sformatf("vec%0d err", i), 64'(err_o),          64'(vecs[i].e_err));
            if (vecs[i].e_core_v)
                check($sformatf("vec%0d core_op", i), 64'(core_op_o), 64'(vecs[i].op));
        end

        // ---------------- part 2: addresses and same-cycle collisions ----------------
        drive(1, 2'd0, 0, 0, 0, 0, '0);
        drive(0, 2'd2, 1, 1, 0, 0, '0);            // WTLD0
        drive(0, 2'd3, 1, 1, 0, 0, '0);            // WTLD1
        drive(0, 2'd0, 1, 1, 0, 0, '0);            // ACLD0, 1 credit left
        drive(0, 2'd0, 1, 1, 0, 0, '0);            // ACLD0, 0 credits left
        drive(0, 2'd0, 0, 0, 0, 1, 40'h80_0000_0000 >> 8); // base = 0x80000000
        drive(0, 2'd0, 0, 0, 1, 0, '0);
        check("addr base", 64'(wb_addr_o), 64'h8000_0000);
        drive(0, 2'd0, 1, 1, 1, 0, '0);            // ACLD issue + retire at 1 credit
        check("addr +1", 64'(wb_addr_o), 64'h8000_0010);
        check("collide issue", 64'(core_v_o), 64'd1);
        drive(0, 2'd0, 0, 0, 1, 0, '0);
        check("addr +2", 64'(wb_addr_o), 64'h8000_0020);
        check("credits held at 1", 64'(busy_o), 64'd1);
        drive(0, 2'd0, 0, 0, 0, 0, '0);
        check("addr +3", 64'(wb_addr_o), 64'h8000_0030);
        check("drained busy", 64'(busy_o), 64'd0);
        check("no overflow err", 64'(err_o), 64'd0);
        drive(0, 2'd0, 1, 1, 0, 0, '0);            // ACLD, 1 outstanding
        drive(0, 2'd0, 0, 0, 1, 1, 40'h12_3456_7890);  // base write + retire
        drive(0, 2'd0, 0, 0, 0, 0, '0);
        check("base wins offset", 64'(wb_addr_o), 64'h12_3456_7890);
        check("base wins busy", 64'(busy_o), 64'd0);
        check("base wins err", 64'(err_o), 64'd0);
        drive(0, 2'd0, 0, 0, 1, 0, '0);            // retire with none out -> overflow
        drive(0, 2'd0, 0, 0, 0, 0, '0);
        check("overflow err", 64'(err_o), 64'd1);
        check("overflow credits held", 64'(busy_o), 64'd0);

        // ---------------- part 3: random traffic against the model ----------------
        drive(1, 2'd0, 0, 0, 0, 0, '0);
        m_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rop   = 2'($urandom_range(0, 3));
            wb    = (m_inflight > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 2);
            rbase = AW'({$urandom, $urandom});
            drive($urandom_range(0, 199) == 0, rop, $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 75, wb, $urandom_range(0, 99) < 3, rbase);

            pv        = op_v_i && data_v_i && !reset_i;
            is_wt     = (op_i >= 2);
            can_issue = pv && (is_wt ? (m_inflight == 0)
                                     : (m_armed() && m_inflight < CREDITS));
            bad_acld  = pv && !is_wt && !m_armed();
            exp_addr  = (m_base + m_beats * STRIDE) & AMASK;

            check("rnd core_v",    64'(core_v_o),    64'(can_issue));
            check("rnd op_yumi",   64'(op_yumi_o),   64'(can_issue || bad_acld));
            check("rnd data_yumi", 64'(data_yumi_o), 64'(can_issue || bad_acld));
            check("rnd busy",      64'(busy_o),
                  64'(!reset_i && (m_inflight != 0 || (pv && !can_issue))));
            check("rnd wt_valid",  64'(wt_valid_o),  64'(m_armed()));
            check("rnd err",       64'(err_o),       64'(m_err));
            check("rnd addr",      64'(wb_addr_o),   exp_addr);
            if (can_issue)
                check("rnd core_op", 64'(core_op_o), 64'(op_i));

            if (reset_i) begin
                m_reset();
            end else begin
                if (can_issue && op_i == 2'd2) begin
                    m_halves.delete();
                    m_halves.push_back(0);
                end else if (can_issue && op_i == 2'd3) begin
                    if (m_halves.size() == 1) begin
                        m_halves.push_back(1);
                    end else begin
                        m_halves.delete();
                        m_err = 1'b1;
                    end
                end
                if (bad_acld) m_err = 1'b1;
                if (wb_yumi_i && m_inflight == 0) m_err = 1'b1;
                nxt = m_inflight + ((can_issue && !is_wt) ? 1 : 0) - (wb_yumi_i ? 1 : 0);
                if (nxt >= 0) m_inflight = nxt;
                if (base_w_i) begin
                    m_base  = longint'(base_addr_i);
                    m_beats = 0;
                end else if (wb_yumi_i) begin
                    m_beats++;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_be_accel_issue_sched.md
Name: bp_be_accel_issue_sched

Overview:
- Issue scheduler for the tensor accelerator pipe's weight-stationary systolic core.
- Pairs committed accelerator ops from the op queue with wide cache-data beats from the data queue, and enforces weight-load ordering.
- Meters activation issue against free writeback-buffer credits and generates the uncached-store address for each result beat.
- Sits between the op/data FIFOs and the systolic core inside the accel pipe.

Parameters:
credits_p, 2, writeback buffer depth; max in-flight activation results (>=1)
paddr_width_p, 40, store address width
stride_p, 16, bytes added to the store address per accepted result beat (power of two)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
op_i  in  2  head op: 0=ACLD0, 1=ACLD1, 2=WTLD0, 3=WTLD1
op_v_i  in  1  op queue non-empty
op_yumi_o  out  1  pop op queue
data_v_i  in  1  data queue non-empty
data_yumi_o  out  1  pop data queue
core_op_o  out  2  op to core; equals op_i
core_v_o  out  1  issue strobe to core; the core always accepts
wb_yumi_i  in  1  result beat accepted by the store pump
base_addr_i  in  paddr_width_p  destination base address from the CSR
base_w_i  in  1  base CSR write strobe
wb_addr_o  out  paddr_width_p  address for the current result beat
wt_valid_o  out  1  both weight halves are loaded
err_o  out  1  sticky protocol error
busy_o  out  1  results outstanding or issue stalled

Behaviour:
- Clock is clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: state=E_EMPTY, credits=credits_p, offset=0, err_o=0, wt_valid_o=0, core_v_o=0, op_yumi_o=0, data_yumi_o=0, busy_o=0.
- States:
  - E_EMPTY: no weights.
  - E_HALF: WTLD0 loaded.
  - E_ARMED: both halves loaded; wt_valid_o=1 only in this state.
- Pair available: pv = op_v_i & data_v_i.
- Issue conditions, all combinational in the same cycle:
  - WTLD0/WTLD1: issue when pv and credits==credits_p. Weights are never changed while results are in flight.
  - ACLD in E_ARMED: issue when pv and credits!=0.
  - ACLD in E_EMPTY/E_HALF: protocol error. Pop the pair (op_yumi_o=data_yumi_o=1), core_v_o=0, set err_o. State is unchanged.
- On issue: core_v_o = op_yumi_o = data_yumi_o = 1, and core_op_o=op_i. No issue without both queues valid. The yumi outputs never assert without their matching v input.
- Transitions on issue:
  - WTLD0 from any state -> E_HALF. A reload invalidates weights.
  - WTLD1 from E_HALF -> E_ARMED.
  - WTLD1 from E_EMPTY or E_ARMED -> E_EMPTY and set err_o. This pair is still issued to the core.
  - ACLD: state unchanged.
- Credits: decrement on ACLD issue; increment on wb_yumi_i. If both happen in the same cycle, credits are unchanged. wb_yumi_i with credits==credits_p is an overflow: set err_o and hold credits.
- Address:
  - wb_addr_o = base_r + offset (combinational, width paddr_width_p, wraps modulo 2^paddr_width_p).
  - base_w_i loads base_r and clears offset next cycle.
  - wb_yumi_i adds stride_p to offset.
  - If base_w_i and wb_yumi_i occur in the same cycle, base_w_i wins and offset=0.
- busy_o = (credits!=credits_p) | (pv & ~issue_now).
- err_o clears only on reset.
- Reset asserted mid-operation discards all in-flight credits and state; the queues are flushed externally.
- Latency: issue is same-cycle with the pair becoming valid when conditions hold. Credit, state and address updates are visible the following cycle.

Test Plan:
- Reset, then WTLD0+data, then WTLD1+data -> core_v_o pulses 2 cycles with core_op_o 2 then 3; wt_valid_o=1 from the cycle after the second issue.
- Armed, credits_p=2, 3 ACLD0 pairs queued, no wb_yumi_i -> 2 issues, third stalls with busy_o=1; one wb_yumi_i -> third issues the next cycle.
- base_w_i with 0x8000_0000, then 3 wb_yumi_i -> wb_addr_o steps 0x80000000, 0x80000010, 0x80000020, 0x80000030.
- ACLD1 pair queued after reset (E_EMPTY) -> pair popped, core_v_o=0, err_o=1 sticky, state stays E_EMPTY.
- Armed with 1 result outstanding, WTLD0 at head -> stall until wb_yumi_i; then issue and state E_HALF, wt_valid_o=0.
- Same-cycle ACLD issue and wb_yumi_i at credits=1 -> credits stays 1; same-cycle base_w_i and wb_yumi_i -> offset=0.
